// File: rtl/int_ctrl_pkg.sv
// Shared CP0 definitions: exception codes, CP0 register indices, interrupt FSM states
// and the interrupt priority encoder.
package int_ctrl_pkg;

  localparam int unsigned NUM_HW_IRQ = 6;
  localparam int unsigned NUM_IP     = 8;

  localparam logic [4:0] EX_CODE_INT  = 5'h00;
  localparam logic [4:0] EX_CODE_ADEL = 5'h04;
  localparam logic [4:0] EX_CODE_ADES = 5'h05;
  localparam logic [4:0] EX_CODE_SYS  = 5'h08;
  localparam logic [4:0] EX_CODE_BP   = 5'h09;
  localparam logic [4:0] EX_CODE_RI   = 5'h0a;
  localparam logic [4:0] EX_CODE_OV   = 5'h0c;

  localparam logic [4:0] CP0_REG_STATUS = 5'd12;
  localparam logic [4:0] CP0_REG_CAUSE  = 5'd13;
  localparam logic [4:0] CP0_REG_EPC    = 5'd14;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_SERVICE = 2'd2
  } int_state_e;

  // Highest set index wins (IP7 highest, IP0 lowest).
  function automatic logic [2:0] prio_idx(input logic [NUM_IP-1:0] vec);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 0; i < NUM_IP; i++) begin
      if (vec[i]) idx = 3'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/int_ctrl_irq_sync.sv
// One interrupt line: synchronizer chain plus a history flop for rising-edge detection.
module irq_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic mem_clk,
  input  logic rst,
  input  logic irq_raw,
  output logic sync_dly,
  output logic rise_c
);

  logic [SYNC_STAGES-1:0] chain;
  logic                   prev;

  always_ff @(posedge mem_clk) begin
    if (rst) begin
      chain <= '0;
      prev  <= 1'b0;
    end else begin
      chain <= {chain[SYNC_STAGES-2:0], irq_raw};
      prev  <= chain[SYNC_STAGES-1];
    end
  end

  // History resets low, so a line already high at reset release reads as a rise.
  assign sync_dly = prev;
  assign rise_c   = chain[SYNC_STAGES-1] & ~prev;

endmodule

// File: rtl/int_ctrl.sv
// Interrupt controller: synchronizes device lines, keeps pending state and
// sequences one interrupt request at a time toward the pipeline.
module int_ctrl
  import int_ctrl_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic [5:0]  EDGE_MASK   = 6'b111111
) (
  input  logic       mem_clk,
  input  logic       rst,
  input  logic [5:0] irq_in,
  input  logic       ie,
  input  logic       exl,
  input  logic [7:0] int_mask,
  input  logic [1:0] sw_int,
  input  logic       int_ack,
  input  logic       eret,
  output logic [5:0] int_sig_out,
  output logic       int_req,
  output logic [2:0] int_id,
  output logic       busy
);

  int_state_e state;
  logic [5:0] pending;
  logic [5:0] sync_dly;
  logic [5:0] rise_c;
  logic [5:0] ack_clr_c;
  logic [7:0] eligible_c;

  for (genvar g = 0; g < NUM_HW_IRQ; g++) begin : g_sync
    irq_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .mem_clk  (mem_clk),
      .rst      (rst),
      .irq_raw  (irq_in[g]),
      .sync_dly (sync_dly[g]),
      .rise_c   (rise_c[g])
    );
  end

  assign eligible_c  = {pending, sw_int} & int_mask;
  assign int_sig_out = pending;

  // Acknowledge clears the hardware line being serviced; sw_int lines are not ours.
  always_comb begin
    ack_clr_c = '0;
    if (state == ST_REQ && int_ack && int_id >= 3'd2)
      ack_clr_c = 6'(6'd1 << (int_id - 3'd2));
  end

  // A new edge on the same cycle as its clear keeps the line pending.
  always_ff @(posedge mem_clk) begin
    if (rst) begin
      pending <= '0;
    end else begin
      for (int i = 0; i < NUM_HW_IRQ; i++) begin
        if (EDGE_MASK[i]) pending[i] <= (pending[i] & ~ack_clr_c[i]) | rise_c[i];
        else              pending[i] <= sync_dly[i];
      end
    end
  end

  always_ff @(posedge mem_clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      int_req <= 1'b0;
      int_id  <= 3'd0;
      busy    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (eligible_c != 8'd0 && ie && !exl) begin
            state   <= ST_REQ;
            int_req <= 1'b1;
            int_id  <= prio_idx(eligible_c);
          end
        end
        ST_REQ: begin
          if (int_ack) begin
            state   <= ST_SERVICE;
            int_req <= 1'b0;
            busy    <= 1'b1;
          end else if (!eligible_c[int_id] || !ie || exl) begin
            state   <= ST_IDLE;
            int_req <= 1'b0;
          end
        end
        ST_SERVICE: begin
          if (eret) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state   <= ST_IDLE;
          int_req <= 1'b0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule
